set_bit_sequencer: RTL and testbench

SET_BIT_SEQUENCER -- requirements
Module: set_bit_sequencer

---
 rtl/set_bit_sequencer.sv | 86 ++++++++
 tb/tb_set_bit_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/set_bit_sequencer.sv
// set_bit_sequencer
//
// Accepts a request vector and issues the index of every set bit, one per
// handshake, from the most-significant set bit down to bit 0. A vector with
// no bits set is consumed silently. While indices are being issued, no new
// vector is accepted.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   in_vld    : input vector valid
//   in_rdy    : block can accept a vector this cycle (idle)
//   vector    : pending requests, one bit per requester
//   out_vld   : location/last valid
//   out_rdy   : consumer takes the current location this cycle
//   location  : index being issued, zero-extended to 16 bits
//   last      : final index for the accepted vector
module set_bit_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] vector,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [15:0]      location,
  output logic             last
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pop_mask;

  // Outputs are decoded purely from the state and pending registers, so no
  // input reaches an output combinationally and they hold while stalled.
  assign in_rdy  = (state == IDLE);
  assign out_vld = (state == EMIT);

  // Highest set bit wins: later (higher) indices overwrite lower ones.
  always_comb begin
    location = 16'd0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pending[i]) location = 16'(i);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign last = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);

  assign pop_mask = {{(WIDTH-1){1'b0}}, 1'b1} << location;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      case (state)
        IDLE: begin
          // An all-zero vector is consumed here without leaving IDLE.
          if (in_vld && (vector != '0)) begin
            pending <= vector;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (out_rdy) begin
            pending <= pending & ~pop_mask;
            if (last) state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_bit_sequencer.sv
module tb_set_bit_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_vld;
  logic        in_rdy;
  logic [7:0]  vector;
  logic        out_vld;
  logic        out_rdy;
  logic [15:0] location;
  logic        last;

  logic        in_vld32;
  logic        in_rdy32;
  logic [31:0] vector32;
  logic        out_vld32;
  logic        out_rdy32;
  logic [15:0] location32;
  logic        last32;

  int n_checks = 0;
  int n_fail   = 0;

  // {out_vld, location, last, in_rdy}
  logic [18:0] got;
  logic [18:0] want;

  always #5 clk = ~clk;

  set_bit_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .vector(vector),
    .out_vld(out_vld), .out_rdy(out_rdy), .location(location), .last(last)
  );

  set_bit_sequencer #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld32), .in_rdy(in_rdy32), .vector(vector32),
    .out_vld(out_vld32), .out_rdy(out_rdy32), .location(location32), .last(last32)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_vld = 1'b1; vector = 8'hFF; out_rdy = 1'b1;
    in_vld32 = 1'b1; vector32 = 32'hFFFF_FFFF; out_rdy32 = 1'b1;
    #1;
    step();
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b0, 16'd0, 1'b0, 1'b1};
    if (got !== want) begin $display("FAIL reset8 got %h want %h", got, want); n_fail++; end
    n_checks++;
    got = {out_vld32, location32, last32, in_rdy32}; want = {1'b0, 16'd0, 1'b0, 1'b1};
    if (got !== want) begin $display("FAIL reset32 got %h want %h", got, want); n_fail++; end
    n_checks++;
    @(negedge clk);
    rst_n = 1'b1;
    in_vld = 1'b0; vector = 8'h00; out_rdy = 1'b0;
    in_vld32 = 1'b0; vector32 = 32'h0; out_rdy32 = 1'b0;
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b0, 16'd0, 1'b0, 1'b1};
    if (got !== want) begin $display("FAIL post_reset_idle got %h want %h", got, want); n_fail++; end
    n_checks++;
  endtask

  task automatic test_descending();
    in_vld = 1'b1; vector = 8'hA4; out_rdy = 1'b1;
    step();
    in_vld = 1'b0; vector = 8'h00;
    got = {out_vld, location, last, in_rdy}; want = {1'b1, 16'd7, 1'b0, 1'b0};
    if (got !== want) begin $display("FAIL a4_loc7 got %h want %h", got, want); n_fail++; end
    n_checks++;
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b1, 16'd5, 1'b0, 1'b0};
    if (got !== want) begin $display("FAIL a4_loc5 got %h want %h", got, want); n_fail++; end
    n_checks++;
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b1, 16'd2, 1'b1, 1'b0};
    if (got !== want) begin $display("FAIL a4_loc2_last got %h want %h", got, want); n_fail++; end
    n_checks++;
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b0, 16'd0, 1'b0, 1'b1};
    if (got !== want) begin $display("FAIL a4_idle got %h want %h", got, want); n_fail++; end
    n_checks++;
  endtask

  task automatic test_stall();
    in_vld = 1'b1; vector = 8'h81; out_rdy = 1'b0;
    step();
    in_vld = 1'b0; vector = 8'h00;
    for (int c = 0; c < 3; c++) begin
      got = {out_vld, location, last, in_rdy}; want = {1'b1, 16'd7, 1'b0, 1'b0};
      if (got !== want) begin $display("FAIL stall_hold%0d got %h want %h", c, got, want); n_fail++; end
      n_checks++;
      if (c < 2) step();
    end
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b1, 16'd7, 1'b0, 1'b0};
    if (got !== want) begin $display("FAIL stall_hold3 got %h want %h", got, want); n_fail++; end
    n_checks++;
    out_rdy = 1'b1;
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b1, 16'd0, 1'b1, 1'b0};
    if (got !== want) begin $display("FAIL stall_loc0_last got %h want %h", got, want); n_fail++; end
    n_checks++;
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b0, 16'd0, 1'b0, 1'b1};
    if (got !== want) begin $display("FAIL stall_idle got %h want %h", got, want); n_fail++; end
    n_checks++;
  endtask

  task automatic test_zero_vector();
    in_vld = 1'b1; vector = 8'h00; out_rdy = 1'b1;
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b0, 16'd0, 1'b0, 1'b1};
    if (got !== want) begin $display("FAIL zero_consumed got %h want %h", got, want); n_fail++; end
    n_checks++;
    vector = 8'h01;
    step();
    in_vld = 1'b0; vector = 8'h00;
    got = {out_vld, location, last, in_rdy}; want = {1'b1, 16'd0, 1'b1, 1'b0};
    if (got !== want) begin $display("FAIL one_loc0_last got %h want %h", got, want); n_fail++; end
    n_checks++;
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b0, 16'd0, 1'b0, 1'b1};
    if (got !== want) begin $display("FAIL one_idle got %h want %h", got, want); n_fail++; end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_loc [0:3];
    exp_loc[0] = 16'd3; exp_loc[1] = 16'd2; exp_loc[2] = 16'd1; exp_loc[3] = 16'd0;
    in_vld = 1'b1; vector = 8'h0F; out_rdy = 1'b1;
    step();
    vector = 8'hF0;
    for (int k = 0; k < 4; k++) begin
      got = {out_vld, location, last, in_rdy}; want = {1'b1, exp_loc[k], (k == 3), 1'b0};
      if (got !== want) begin $display("FAIL b2b_0f_%0d got %h want %h", k, got, want); n_fail++; end
      n_checks++;
      step();
    end
    got = {out_vld, location, last, in_rdy}; want = {1'b0, 16'd0, 1'b0, 1'b1};
    if (got !== want) begin $display("FAIL b2b_gap got %h want %h", got, want); n_fail++; end
    n_checks++;
    step();
    in_vld = 1'b0; vector = 8'h00;
    for (int k = 0; k < 4; k++) begin
      got = {out_vld, location, last, in_rdy}; want = {1'b1, 16'(7 - k), (k == 3), 1'b0};
      if (got !== want) begin $display("FAIL b2b_f0_%0d got %h want %h", k, got, want); n_fail++; end
      n_checks++;
      step();
    end
    got = {out_vld, location, last, in_rdy}; want = {1'b0, 16'd0, 1'b0, 1'b1};
    if (got !== want) begin $display("FAIL b2b_idle got %h want %h", got, want); n_fail++; end
    n_checks++;
  endtask

  task automatic test_reset_mid_emit();
    in_vld = 1'b1; vector = 8'hFF; out_rdy = 1'b1;
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b1, 16'd7, 1'b0, 1'b0};
    if (got !== want) begin $display("FAIL ff_loc7 got %h want %h", got, want); n_fail++; end
    n_checks++;
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b1, 16'd6, 1'b0, 1'b0};
    if (got !== want) begin $display("FAIL ff_loc6 got %h want %h", got, want); n_fail++; end
    n_checks++;
    #2;
    rst_n = 1'b0;
    #1;
    got = {out_vld, location, last, in_rdy}; want = {1'b0, 16'd0, 1'b0, 1'b1};
    if (got !== want) begin $display("FAIL async_reset got %h want %h", got, want); n_fail++; end
    n_checks++;
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b0, 16'd0, 1'b0, 1'b1};
    if (got !== want) begin $display("FAIL reset_held got %h want %h", got, want); n_fail++; end
    n_checks++;
    in_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b0, 16'd0, 1'b0, 1'b1};
    if (got !== want) begin $display("FAIL no_stale_output got %h want %h", got, want); n_fail++; end
    n_checks++;
    rst_n = 1'b0;
    #1;
    in_vld = 1'b1; vector = 8'h03;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    in_vld = 1'b0; vector = 8'h00;
    got = {out_vld, location, last, in_rdy}; want = {1'b1, 16'd1, 1'b0, 1'b0};
    if (got !== want) begin $display("FAIL first_edge_accept got %h want %h", got, want); n_fail++; end
    n_checks++;
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b1, 16'd0, 1'b1, 1'b0};
    if (got !== want) begin $display("FAIL new_vec_loc0 got %h want %h", got, want); n_fail++; end
    n_checks++;
    step();
    got = {out_vld, location, last, in_rdy}; want = {1'b0, 16'd0, 1'b0, 1'b1};
    if (got !== want) begin $display("FAIL new_vec_idle got %h want %h", got, want); n_fail++; end
    n_checks++;
  endtask

  task automatic test_wide();
    in_vld32 = 1'b1; vector32 = 32'h8000_0001; out_rdy32 = 1'b1;
    step();
    in_vld32 = 1'b0; vector32 = 32'h0;
    got = {out_vld32, location32, last32, in_rdy32}; want = {1'b1, 16'd31, 1'b0, 1'b0};
    if (got !== want) begin $display("FAIL w32_loc31 got %h want %h", got, want); n_fail++; end
    n_checks++;
    step();
    got = {out_vld32, location32, last32, in_rdy32}; want = {1'b1, 16'd0, 1'b1, 1'b0};
    if (got !== want) begin $display("FAIL w32_loc0_last got %h want %h", got, want); n_fail++; end
    n_checks++;
    step();
    got = {out_vld32, location32, last32, in_rdy32}; want = {1'b0, 16'd0, 1'b0, 1'b1};
    if (got !== want) begin $display("FAIL w32_idle got %h want %h", got, want); n_fail++; end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_descending();
    test_stall();
    test_zero_vector();
    test_back_to_back();
    test_reset_mid_emit();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
